// File: rtl/efuse_pkg.sv
// Shared types and constants for the eFuse trim shadow register and its CRC-8 check.
package efuse_pkg;

  localparam int EFUSE_BITS = 256;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  localparam logic [1:0] TRIM_ERR_NONE    = 2'b00;
  localparam logic [1:0] TRIM_ERR_CRC     = 2'b01;
  localparam logic [1:0] TRIM_ERR_SHORT   = 2'b10;
  localparam logic [1:0] TRIM_ERR_OVERRUN = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_VALID,
    ST_ERROR
  } efuse_shadow_state_e;

endpackage

// File: rtl/efuse_crc8_step.sv
// Combinational single-byte CRC-8 update, MSB-first, polynomial from efuse_pkg.
module efuse_crc8_step
  import efuse_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] byte_in,
  output logic [7:0] crc_out
);

  always_comb begin
    logic [7:0] c;
    c = crc_in ^ byte_in;
    for (int b = 0; b < 8; b++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/efuse_trim_shadow.sv
// Captures the eFuse autoload stream into a 256-bit shadow and publishes it with valid/error status.
// Define EFUSE_SHADOW_CRC_EN to add the CRC-8 integrity check (CHECK state) before VALID.
module efuse_trim_shadow
  import efuse_pkg::*;
#(
  parameter int NR = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            efuse_autoload_vld,
  input  logic [NR-1:0]   efuse_rdata,
  input  logic            efuse_autoload_done,
  output logic [255:0]    trim_shadow,
  output logic            trim_valid,
  output logic [1:0]      trim_err,
  output logic            trim_busy
);

  localparam int WORDS = EFUSE_BITS / NR;
  localparam int CNT_W = $clog2(WORDS + 1);

  efuse_shadow_state_e state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [255:0]        shadow_q, shadow_d;
  logic                valid_q, valid_d;
  logic [1:0]          err_q, err_d;
  logic                overrun_q, overrun_d;
  // A load outcome decided at the done edge is published one cycle later.
  logic                pend_q, pend_d;
  logic [1:0]          pend_err_q, pend_err_d;

`ifdef EFUSE_SHADOW_CRC_EN
  logic [7:0]          crc_q, crc_d;
  logic [4:0]          byte_idx_q, byte_idx_d;
  logic [7:0]          crc_byte;
  logic [7:0]          crc_next;

  assign crc_byte = shadow_q[{byte_idx_q, 3'b000} +: 8];

  efuse_crc8_step u_crc8_step (
    .crc_in  (crc_q),
    .byte_in (crc_byte),
    .crc_out (crc_next)
  );
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    valid_d    = valid_q;
    err_d      = err_q;
    overrun_d  = overrun_q;
    pend_d     = pend_q;
    pend_err_d = pend_err_q;
`ifdef EFUSE_SHADOW_CRC_EN
    crc_d      = crc_q;
    byte_idx_d = byte_idx_q;
`endif

    unique case (state_q)
      ST_IDLE, ST_VALID, ST_ERROR: begin
        if (efuse_autoload_vld) begin
          shadow_d[NR-1:0] = efuse_rdata;
          cnt_d            = CNT_W'(1);
          valid_d          = 1'b0;
          err_d            = TRIM_ERR_NONE;
          overrun_d        = 1'b0;
          pend_d           = 1'b0;
          pend_err_d       = TRIM_ERR_NONE;
          state_d          = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (pend_q) begin
          pend_d = 1'b0;
          if (pend_err_q != TRIM_ERR_NONE) begin
            err_d   = pend_err_q;
            state_d = ST_ERROR;
          end else begin
            valid_d = 1'b1;
            state_d = ST_VALID;
          end
        end else begin
          if (efuse_autoload_vld) begin
            if (cnt_q < CNT_W'(WORDS)) begin
              for (int k = 0; k < WORDS; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                  shadow_d[k*NR +: NR] = efuse_rdata;
                end
              end
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              overrun_d = 1'b1;
            end
          end
          // Done is judged against the count and flag after this cycle's word.
          if (efuse_autoload_done) begin
            if (cnt_d < CNT_W'(WORDS)) begin
              pend_d     = 1'b1;
              pend_err_d = TRIM_ERR_SHORT;
            end else if (overrun_d) begin
              pend_d     = 1'b1;
              pend_err_d = TRIM_ERR_OVERRUN;
            end else begin
`ifdef EFUSE_SHADOW_CRC_EN
              crc_d      = CRC8_INIT;
              byte_idx_d = 5'd0;
              state_d    = ST_CHECK;
`else
              pend_d     = 1'b1;
              pend_err_d = TRIM_ERR_NONE;
`endif
            end
          end
        end
      end

      ST_CHECK: begin
`ifdef EFUSE_SHADOW_CRC_EN
        if (byte_idx_q != 5'd31) begin
          crc_d      = crc_next;
          byte_idx_d = byte_idx_q + 5'd1;
        end else if (crc_q == shadow_q[255:248]) begin
          valid_d = 1'b1;
          state_d = ST_VALID;
        end else begin
          err_d   = TRIM_ERR_CRC;
          state_d = ST_ERROR;
        end
`else
        state_d = ST_IDLE;
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shadow_q   <= '0;
      valid_q    <= 1'b0;
      err_q      <= TRIM_ERR_NONE;
      overrun_q  <= 1'b0;
      pend_q     <= 1'b0;
      pend_err_q <= TRIM_ERR_NONE;
`ifdef EFUSE_SHADOW_CRC_EN
      crc_q      <= CRC8_INIT;
      byte_idx_q <= 5'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      overrun_q  <= overrun_d;
      pend_q     <= pend_d;
      pend_err_q <= pend_err_d;
`ifdef EFUSE_SHADOW_CRC_EN
      crc_q      <= crc_d;
      byte_idx_q <= byte_idx_d;
`endif
    end
  end

  assign trim_shadow = shadow_q;
  assign trim_valid  = valid_q;
  assign trim_err    = err_q;
  assign trim_busy   = (state_q == ST_LOAD) || (state_q == ST_CHECK);

endmodule

// File: tb/tb_efuse_trim_shadow.sv
// Directed testbench for efuse_trim_shadow (NR=64); expectations follow EFUSE_SHADOW_CRC_EN.
module tb_efuse_trim_shadow;

  logic         clk;
  logic         rst_n;
  logic         efuse_autoload_vld;
  logic [63:0]  efuse_rdata;
  logic         efuse_autoload_done;
  logic [255:0] trim_shadow;
  logic         trim_valid;
  logic [1:0]   trim_err;
  logic         trim_busy;

  int checks   = 0;
  int failures = 0;

  logic [255:0] prev_img;

  efuse_trim_shadow #(.NR(64)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .efuse_autoload_vld  (efuse_autoload_vld),
    .efuse_rdata         (efuse_rdata),
    .efuse_autoload_done (efuse_autoload_done),
    .trim_shadow         (trim_shadow),
    .trim_valid          (trim_valid),
    .trim_err            (trim_err),
    .trim_busy           (trim_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference CRC-8 (poly 0x07, init 0x00, MSB-first) over bytes 0..30.
  function automatic logic [7:0] crc8_model(input logic [255:0] img);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 31; i++) begin
      c = c ^ img[8*i +: 8];
      for (int b = 0; b < 8; b++) begin
        c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [63:0] data, input logic v, input logic d);
    efuse_autoload_vld  = v;
    efuse_rdata         = data;
    efuse_autoload_done = d;
    @(posedge clk);
    #1;
    efuse_autoload_vld  = 1'b0;
    efuse_autoload_done = 1'b0;
    efuse_rdata         = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    efuse_autoload_vld  = 1'b0;
    efuse_autoload_done = 1'b0;
    efuse_rdata         = '0;
    step(3);
    checks++; if (trim_shadow !== 256'h0) begin failures++; $display("[TB] FAIL reset_shadow actual=%h expected=0", trim_shadow); end
    checks++; if (trim_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid actual=%b expected=0", trim_valid); end
    checks++; if (trim_err !== 2'b00) begin failures++; $display("[TB] FAIL reset_err actual=%b expected=00", trim_err); end
    checks++; if (trim_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy actual=%b expected=0", trim_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_clean_load;
    logic [255:0] img;
`ifdef EFUSE_SHADOW_CRC_EN
    img = 256'h0;
`else
    img = {64'hFF00_0000_0000_1234, 64'hA5A5_5A5A_0F0F_F0F0,
           64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
`endif
    pulse(img[63:0], 1'b1, 1'b0);
    checks++; if (trim_busy !== 1'b1) begin failures++; $display("[TB] FAIL clean_busy_rise actual=%b expected=1", trim_busy); end
    checks++; if (trim_shadow[63:0] !== img[63:0]) begin failures++; $display("[TB] FAIL clean_word0 actual=%h expected=%h", trim_shadow[63:0], img[63:0]); end
    for (int i = 1; i < 4; i++) pulse(img[i*64 +: 64], 1'b1, 1'b0);
    pulse(64'h0, 1'b0, 1'b1);
    checks++; if (trim_valid !== 1'b0) begin failures++; $display("[TB] FAIL clean_valid_t0 actual=%b expected=0", trim_valid); end
`ifdef EFUSE_SHADOW_CRC_EN
    step(31);
    checks++; if (trim_valid !== 1'b0) begin failures++; $display("[TB] FAIL clean_valid_t31 actual=%b expected=0", trim_valid); end
    checks++; if (trim_busy !== 1'b1) begin failures++; $display("[TB] FAIL clean_busy_t31 actual=%b expected=1", trim_busy); end
`endif
    step(1);
    checks++; if (trim_valid !== 1'b1) begin failures++; $display("[TB] FAIL clean_valid actual=%b expected=1", trim_valid); end
    checks++; if (trim_err !== 2'b00) begin failures++; $display("[TB] FAIL clean_err actual=%b expected=00", trim_err); end
    checks++; if (trim_busy !== 1'b0) begin failures++; $display("[TB] FAIL clean_busy_fall actual=%b expected=0", trim_busy); end
    checks++; if (trim_shadow !== img) begin failures++; $display("[TB] FAIL clean_shadow actual=%h expected=%h", trim_shadow, img); end
    prev_img = img;
  endtask

`ifdef EFUSE_SHADOW_CRC_EN
  task automatic test_crc_mismatch;
    logic [255:0] img;
    img = {64'h0100_0000_0000_0000, 192'h0};
    for (int i = 0; i < 4; i++) pulse(img[i*64 +: 64], 1'b1, 1'b0);
    pulse(64'h0, 1'b0, 1'b1);
    step(32);
    checks++; if (trim_valid !== 1'b0) begin failures++; $display("[TB] FAIL crc_bad_valid actual=%b expected=0", trim_valid); end
    checks++; if (trim_err !== 2'b01) begin failures++; $display("[TB] FAIL crc_bad_err actual=%b expected=01", trim_err); end
    checks++; if (trim_busy !== 1'b0) begin failures++; $display("[TB] FAIL crc_bad_busy actual=%b expected=0", trim_busy); end
  endtask

  task automatic test_crc_data;
    logic [255:0] img;
    img = {8'h00, 56'h11_2233_4455_6677, 64'hA5A5_5A5A_0F0F_F0F0,
           64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
    img[255:248] = crc8_model(img);
    for (int i = 0; i < 4; i++) pulse(img[i*64 +: 64], 1'b1, 1'b0);
    pulse(64'h0, 1'b0, 1'b1);
    step(32);
    checks++; if (trim_valid !== 1'b1) begin failures++; $display("[TB] FAIL crc_data_valid actual=%b expected=1", trim_valid); end
    checks++; if (trim_err !== 2'b00) begin failures++; $display("[TB] FAIL crc_data_err actual=%b expected=00", trim_err); end
    prev_img = img;
  endtask
`endif

  task automatic test_short_load;
    logic [191:0] data;
    data = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    for (int i = 0; i < 3; i++) pulse(data[i*64 +: 64], 1'b1, 1'b0);
    pulse(64'h0, 1'b0, 1'b1);
    checks++; if (trim_err !== 2'b00) begin failures++; $display("[TB] FAIL short_err_t0 actual=%b expected=00", trim_err); end
    step(1);
    checks++; if (trim_err !== 2'b10) begin failures++; $display("[TB] FAIL short_err actual=%b expected=10", trim_err); end
    checks++; if (trim_valid !== 1'b0) begin failures++; $display("[TB] FAIL short_valid actual=%b expected=0", trim_valid); end
    checks++; if (trim_busy !== 1'b0) begin failures++; $display("[TB] FAIL short_busy actual=%b expected=0", trim_busy); end
    checks++; if (trim_shadow[191:0] !== data) begin failures++; $display("[TB] FAIL short_low actual=%h expected=%h", trim_shadow[191:0], data); end
    checks++; if (trim_shadow[255:192] !== prev_img[255:192]) begin failures++; $display("[TB] FAIL short_high actual=%h expected=%h", trim_shadow[255:192], prev_img[255:192]); end
  endtask

  task automatic test_overrun_same_cycle;
    logic [255:0] img;
    img = {64'h4444_0000_4444_0000, 64'h3030_3030_3030_3030,
           64'h2020_2020_2020_2020, 64'h1010_1010_1010_1010};
    pulse(img[63:0], 1'b1, 1'b0);
    checks++; if (trim_err !== 2'b00) begin failures++; $display("[TB] FAIL ovr_err_cleared actual=%b expected=00", trim_err); end
    for (int i = 1; i < 4; i++) pulse(img[i*64 +: 64], 1'b1, 1'b0);
    pulse(64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 1'b1);
    step(1);
    checks++; if (trim_err !== 2'b11) begin failures++; $display("[TB] FAIL ovr_err actual=%b expected=11", trim_err); end
    checks++; if (trim_valid !== 1'b0) begin failures++; $display("[TB] FAIL ovr_valid actual=%b expected=0", trim_valid); end
    checks++; if (trim_shadow !== img) begin failures++; $display("[TB] FAIL ovr_shadow actual=%h expected=%h", trim_shadow, img); end
  endtask

  task automatic test_reload_and_reset;
    logic [255:0] img;
`ifdef EFUSE_SHADOW_CRC_EN
    img = 256'h0;
`else
    img = {64'h0F0F_0000_1111_2222, 64'h9999_8888_7777_6666,
           64'h5555_4444_3333_2222, 64'h1357_9BDF_2468_ACE0};
`endif
    for (int i = 0; i < 3; i++) pulse(img[i*64 +: 64], 1'b1, 1'b0);
    pulse(img[255:192], 1'b1, 1'b1);
`ifdef EFUSE_SHADOW_CRC_EN
    step(32);
`else
    step(1);
`endif
    checks++; if (trim_valid !== 1'b1) begin failures++; $display("[TB] FAIL same_cycle_valid actual=%b expected=1", trim_valid); end
    checks++; if (trim_err !== 2'b00) begin failures++; $display("[TB] FAIL same_cycle_err actual=%b expected=00", trim_err); end
    pulse(64'hCAFE_F00D_CAFE_F00D, 1'b1, 1'b0);
    checks++; if (trim_valid !== 1'b0) begin failures++; $display("[TB] FAIL reload_valid actual=%b expected=0", trim_valid); end
    checks++; if (trim_busy !== 1'b1) begin failures++; $display("[TB] FAIL reload_busy actual=%b expected=1", trim_busy); end
    checks++; if (trim_shadow[63:0] !== 64'hCAFE_F00D_CAFE_F00D) begin failures++; $display("[TB] FAIL reload_word0 actual=%h expected=cafef00dcafef00d", trim_shadow[63:0]); end
    checks++; if (trim_shadow[255:64] !== img[255:64]) begin failures++; $display("[TB] FAIL reload_rest actual=%h expected=%h", trim_shadow[255:64], img[255:64]); end
    pulse(64'h1, 1'b1, 1'b0);
`ifdef EFUSE_SHADOW_CRC_EN
    pulse(64'h2, 1'b1, 1'b0);
    pulse(64'h3, 1'b1, 1'b1);
    step(5);
`endif
    rst_n = 1'b0;
    #1;
    checks++; if (trim_shadow !== 256'h0) begin failures++; $display("[TB] FAIL midrst_shadow actual=%h expected=0", trim_shadow); end
    checks++; if (trim_busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy actual=%b expected=0", trim_busy); end
    checks++; if (trim_valid !== 1'b0 || trim_err !== 2'b00) begin failures++; $display("[TB] FAIL midrst_status actual=%b/%b expected=0/00", trim_valid, trim_err); end
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    pulse(64'h0, 1'b0, 1'b1);
    step(1);
    checks++; if (trim_busy !== 1'b0 || trim_err !== 2'b00 || trim_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_done busy/err/valid actual=%b/%b/%b expected=0/00/0", trim_busy, trim_err, trim_valid); end
  endtask

  initial begin
    test_reset();
    test_clean_load();
`ifdef EFUSE_SHADOW_CRC_EN
    test_crc_mismatch();
    test_crc_data();
`endif
    test_short_load();
    test_overrun_same_cycle();
    test_reload_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
